// File: rtl/apu_pulse_sequencer.sv
// Note-table sequencer for one apu_pulse channel; registered outputs, vld 2 cycles after start/advance.
// Backpressure: period/duty vld hold stable until their rdy; notes are timed by accepted mon samples.
module apu_pulse_sequencer #(
    parameter int DEPTH    = 8,
    parameter int PERIOD_W = 11,
    parameter int DUTY_W   = 2,
    parameter int DUR_W    = 8,
    localparam int AW      = $clog2(DEPTH),
    localparam int ENTRY_W = DUR_W + DUTY_W + PERIOD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [ENTRY_W-1:0]  wr_data,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    output logic                busy,
    output logic [AW-1:0]       note_idx,
    output logic                done,
    output logic                mute,
    output logic [PERIOD_W-1:0] period_s,
    output logic                period_s_vld,
    input  logic                period_s_rdy,
    output logic [DUTY_W-1:0]   duty_s,
    output logic                duty_s_vld,
    input  logic                duty_s_rdy,
    input  logic                mon_vld,
    input  logic                mon_rdy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_PLAY
    } state_t;

    logic [ENTRY_W-1:0] table_q [DEPTH];

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [DUR_W-1:0]    cnt_q, cnt_d;
    logic [DUR_W-1:0]    cur_dur_q, cur_dur_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                period_vld_q, period_vld_d;
    logic                duty_vld_q, duty_vld_d;
    logic                stop_pend_q, stop_pend_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                mute_q, mute_d;

    logic [ENTRY_W-1:0]  rd_entry;
    logic [DUR_W-1:0]    rd_dur;
    logic [DUTY_W-1:0]   rd_duty;
    logic [PERIOD_W-1:0] rd_period;
    logic                sample;
    logic                last_idx;
    logic                last_sample;

    // Table is deliberately left unreset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    assign rd_entry    = table_q[idx_q];
    assign rd_dur      = rd_entry[ENTRY_W-1 -: DUR_W];
    assign rd_duty     = rd_entry[PERIOD_W +: DUTY_W];
    assign rd_period   = rd_entry[PERIOD_W-1:0];
    assign sample      = mon_vld & mon_rdy;
    assign last_idx    = (idx_q == AW'(DEPTH - 1));
    assign last_sample = (cnt_q == cur_dur_q - DUR_W'(1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        cur_dur_d    = cur_dur_q;
        period_d     = period_q;
        duty_d       = duty_q;
        period_vld_d = period_vld_q;
        duty_vld_d   = duty_vld_q;
        stop_pend_d  = stop_pend_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (start && !stop) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end

            S_LOAD: begin
                if (stop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (rd_dur == '0) begin
                    // End marker: wrap once to entry 0, but never spin on an empty entry 0.
                    if (loop_en && (idx_q != '0)) begin
                        idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cur_dur_d    = rd_dur;
                    period_d     = rd_period;
                    duty_d       = rd_duty;
                    period_vld_d = 1'b1;
                    duty_vld_d   = 1'b1;
                    state_d      = S_SEND;
                end
            end

            S_SEND: begin
                period_vld_d = period_vld_q & ~period_s_rdy;
                duty_vld_d   = duty_vld_q & ~duty_s_rdy;
                stop_pend_d  = stop_pend_q | stop;
                // A stop here is deferred until both handshakes have drained.
                if (!period_vld_d && !duty_vld_d) begin
                    if (stop_pend_d) begin
                        state_d     = S_IDLE;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
                    end
                end
            end

            S_PLAY: begin
                if (stop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (sample) begin
                    if (last_sample) begin
                        cnt_d = '0;
                        if (!last_idx) begin
                            idx_d   = idx_q + AW'(1);
                            state_d = S_LOAD;
                        end else if (loop_en) begin
                            idx_d   = '0;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + DUR_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        mute_d = (state_d != S_PLAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            cur_dur_q    <= '0;
            period_q     <= '0;
            duty_q       <= '0;
            period_vld_q <= 1'b0;
            duty_vld_q   <= 1'b0;
            stop_pend_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            mute_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            cur_dur_q    <= cur_dur_d;
            period_q     <= period_d;
            duty_q       <= duty_d;
            period_vld_q <= period_vld_d;
            duty_vld_q   <= duty_vld_d;
            stop_pend_q  <= stop_pend_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            mute_q       <= mute_d;
        end
    end

    assign busy         = busy_q;
    assign note_idx     = idx_q;
    assign done         = done_q;
    assign mute         = mute_q;
    assign period_s     = period_q;
    assign period_s_vld = period_vld_q;
    assign duty_s       = duty_q;
    assign duty_s_vld   = duty_vld_q;

endmodule

// File: tb/tb_apu_pulse_sequencer.sv
// Directed bench for apu_pulse_sequencer: expected handshakes, note indices and note
// lengths are queued when stimulus is issued and checked as the DUT produces them.
module tb_apu_pulse_sequencer;

    localparam int DEPTH = 8;
    localparam int PW    = 11;
    localparam int DW    = 2;
    localparam int RW    = 8;
    localparam int AW    = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [RW+DW+PW-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic              busy;
    logic [AW-1:0]     note_idx;
    logic              done;
    logic              mute;
    logic [PW-1:0]     period_s;
    logic              period_s_vld;
    logic              period_s_rdy = 1'b1;
    logic [DW-1:0]     duty_s;
    logic              duty_s_vld;
    logic              duty_s_rdy = 1'b1;
    logic              mon_vld = 1'b0;
    logic              mon_rdy = 1'b0;

    always #5 clk = ~clk;

    apu_pulse_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .busy         (busy),
        .note_idx     (note_idx),
        .done         (done),
        .mute         (mute),
        .period_s     (period_s),
        .period_s_vld (period_s_vld),
        .period_s_rdy (period_s_rdy),
        .duty_s       (duty_s),
        .duty_s_vld   (duty_s_vld),
        .duty_s_rdy   (duty_s_rdy),
        .mon_vld      (mon_vld),
        .mon_rdy      (mon_rdy)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_per[$];
    logic [31:0] exp_duty[$];
    logic [31:0] exp_idx[$];
    logic [31:0] exp_run[$];

    int per_hs   = 0;
    int duty_hs  = 0;
    int done_cnt = 0;
    int vld_cyc  = 0;
    int run      = 0;
    bit chk_runs = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, so a vld&rdy seen here completes at the next rise.
    always @(negedge clk) begin
        if (reset) begin
            run = 0;
        end else begin
            if (period_s_vld) vld_cyc++;
            if (duty_s_vld) vld_cyc++;
            if (period_s_vld && period_s_rdy) begin
                per_hs++;
                if (exp_per.size() == 0) begin
                    check("per_unexpected", 32'(period_s), 32'hFFFF_FFFF);
                end else begin
                    check("per_dat", 32'(period_s), exp_per.pop_front());
                    check("per_idx", 32'(note_idx), exp_idx.pop_front());
                end
            end
            if (duty_s_vld && duty_s_rdy) begin
                duty_hs++;
                if (exp_duty.size() == 0) begin
                    check("duty_unexpected", 32'(duty_s), 32'hFFFF_FFFF);
                end else begin
                    check("duty_dat", 32'(duty_s), exp_duty.pop_front());
                end
            end
            if (done) done_cnt++;
            if (mute) begin
                if (run > 0 && chk_runs) begin
                    if (exp_run.size() == 0) check("play_len_unexpected", 32'(run), 32'hFFFF_FFFF);
                    else check("play_len", 32'(run), exp_run.pop_front());
                end
                run = 0;
            end else if (mon_vld && mon_rdy) begin
                run++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int a, input int dur, input int duty, input int per);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = {RW'(dur), DW'(duty), PW'(per)};
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic push(input int per, input int duty, input int idx);
        exp_per.push_back(32'(per));
        exp_duty.push_back(32'(duty));
        exp_idx.push_back(32'(idx));
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int budget, input string tag);
        int n = 0;
        while (per_hs < target && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(per_hs >= target), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_per_q"}, 32'(exp_per.size()), 32'd0);
        check({tag, "_duty_q"}, 32'(exp_duty.size()), 32'd0);
        check({tag, "_run_q"}, 32'(exp_run.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int v0;
        int base;
        int n;

        // Reset state
        tick(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mute", 32'(mute), 32'd1);
        check("rst_per_vld", 32'(period_s_vld), 32'd0);
        check("rst_duty_vld", 32'(duty_s_vld), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(note_idx), 32'd0);
        check("rst_period", 32'(period_s), 32'd0);
        reset = 1'b0;
        tick(1);

        // Empty table: end marker at entry 0
        wr(0, 0, 0, 0);
        d0 = done_cnt;
        v0 = vld_cyc;
        start_pulse();
        check("empty_busy_load", 32'(busy), 32'd1);
        tick(1);
        check("empty_done", 32'(done), 32'd1);
        check("empty_idle", 32'(busy), 32'd0);
        tick(1);
        check("empty_done_pulse", 32'(done), 32'd0);
        check("empty_no_vld", 32'(vld_cyc - v0), 32'd0);
        check("empty_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Two-note play, ready held high, continuous samples
        wr(0, 3, 2, 'h1A0);
        wr(1, 2, 1, 'h7FF);
        wr(2, 0, 0, 0);
        mon_vld  = 1'b1;
        mon_rdy  = 1'b1;
        chk_runs = 1'b1;
        push('h1A0, 2, 0);
        push('h7FF, 1, 1);
        exp_run.push_back(3);
        exp_run.push_back(2);
        d0 = done_cnt;
        start_pulse();
        check("two_load_mute", 32'(mute), 32'd1);
        check("two_load_vld", 32'(period_s_vld), 32'd0);
        tick(1);
        check("two_send_per_vld", 32'(period_s_vld), 32'd1);
        check("two_send_duty_vld", 32'(duty_s_vld), 32'd1);
        check("two_send_mute", 32'(mute), 32'd1);
        tick(1);
        check("two_play_mute", 32'(mute), 32'd0);
        check("two_play_vld", 32'(period_s_vld | duty_s_vld), 32'd0);
        wait_done(50, "two_done_seen");
        check("two_final_idx", 32'(note_idx), 32'd2);
        tick(2);
        check("two_done_once", 32'(done_cnt - d0), 32'd1);
        check_drained("two");

        // Skewed ready: duty accepted 5 cycles after period
        duty_s_rdy = 1'b0;
        push('h1A0, 2, 0);
        push('h7FF, 1, 1);
        exp_run.push_back(3);
        exp_run.push_back(2);
        start_pulse();
        tick(1);
        check("skew_both_vld", 32'(period_s_vld & duty_s_vld), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("skew_per_dropped", 32'(period_s_vld), 32'd0);
            check("skew_duty_held", 32'(duty_s_vld), 32'd1);
            check("skew_duty_stable", 32'(duty_s), 32'd2);
            check("skew_no_play", 32'(mute), 32'd1);
        end
        duty_s_rdy = 1'b1;
        tick(1);
        check("skew_play", 32'(mute), 32'd0);
        check("skew_duty_dropped", 32'(duty_s_vld), 32'd0);
        wait_done(50, "skew_done_seen");
        tick(1);
        check_drained("skew");

        // Loop over the two-note table, then stop during PLAY
        loop_en = 1'b1;
        push('h1A0, 2, 0);
        push('h7FF, 1, 1);
        push('h1A0, 2, 0);
        exp_run.push_back(3);
        exp_run.push_back(2);
        d0   = done_cnt;
        base = per_hs;
        start_pulse();
        wait_hs(base + 3, 60, "loop_reissue");
        chk_runs = 1'b0;
        check("loop_no_done", 32'(done_cnt - d0), 32'd0);
        check("loop_in_play", 32'(mute), 32'd0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("stop_play_idle", 32'(busy), 32'd0);
        check("stop_play_done", 32'(done), 32'd1);
        check("stop_play_mute", 32'(mute), 32'd1);
        tick(1);
        check_drained("loop");

        // Full table wraps from DEPTH-1 to 0
        for (int i = 0; i < DEPTH; i++) wr(i, 1, i % 4, 'h10 + i);
        for (int i = 0; i < DEPTH; i++) begin
            push('h10 + i, i % 4, i);
            exp_run.push_back(1);
        end
        push('h10, 0, 0);
        chk_runs = 1'b1;
        base = per_hs;
        start_pulse();
        wait_hs(base + DEPTH + 1, 200, "wrap_reissue");
        chk_runs = 1'b0;
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        loop_en = 1'b0;
        check("wrap_stop_done", 32'(done), 32'd1);
        tick(1);
        check_drained("wrap");

        // Stop during SEND with both ready low: vld held until accepted
        period_s_rdy = 1'b0;
        duty_s_rdy   = 1'b0;
        push('h10, 0, 0);
        start_pulse();
        tick(1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("ssend_per_held", 32'(period_s_vld), 32'd1);
        check("ssend_duty_held", 32'(duty_s_vld), 32'd1);
        check("ssend_busy", 32'(busy), 32'd1);
        tick(3);
        check("ssend_per_still", 32'(period_s_vld), 32'd1);
        check("ssend_period_stable", 32'(period_s), 32'h10);
        check("ssend_no_done", 32'(done), 32'd0);
        check("ssend_mute", 32'(mute), 32'd1);
        period_s_rdy = 1'b1;
        duty_s_rdy   = 1'b1;
        tick(1);
        check("ssend_idle", 32'(busy), 32'd0);
        check("ssend_done", 32'(done), 32'd1);
        check("ssend_vld_low", 32'(period_s_vld | duty_s_vld), 32'd0);
        tick(1);
        check_drained("ssend");

        // Asynchronous reset mid-PLAY; table survives
        wr(0, 200, 3, 'h123);
        push('h123, 3, 0);
        start_pulse();
        tick(2);
        check("arst_in_play", 32'(mute), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_mute", 32'(mute), 32'd1);
        check("arst_vld", 32'(period_s_vld | duty_s_vld), 32'd0);
        check("arst_period", 32'(period_s), 32'd0);
        check("arst_duty", 32'(duty_s), 32'd0);
        check("arst_idx", 32'(note_idx), 32'd0);
        tick(1);
        reset = 1'b0;
        tick(1);
        push('h123, 3, 0);
        base = per_hs;
        start_pulse();
        wait_hs(base + 1, 20, "arst_table_kept");
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("arst_stop_idle", 32'(busy), 32'd0);
        tick(1);
        check_drained("arst");

        // Write collides with LOAD of entry 1: old data now, new data next pass
        loop_en = 1'b1;
        wr(0, 2, 1, 'h0AA);
        wr(1, 2, 2, 'h0BB);
        wr(2, 0, 0, 0);
        push('h0AA, 1, 0);
        push('h0BB, 2, 1);
        push('h0AA, 1, 0);
        push('h0CC, 3, 1);
        exp_run.push_back(2);
        exp_run.push_back(2);
        exp_run.push_back(2);
        chk_runs = 1'b1;
        base = per_hs;
        start_pulse();
        n = 0;
        while (note_idx != AW'(1) && n < 30) begin
            tick(1);
            n++;
        end
        check("coll_at_idx1", 32'(note_idx), 32'd1);
        check("coll_load_mute", 32'(mute), 32'd1);
        wr(1, 2, 3, 'h0CC);
        wait_hs(base + 4, 80, "coll_second_pass");
        chk_runs = 1'b0;
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        loop_en = 1'b0;
        check("coll_stop_idle", 32'(busy), 32'd0);
        tick(2);
        check_drained("coll");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apu_pulse_sequencer.md
# apu_pulse_sequencer

Note sequencer that drives one `apu_pulse` channel. It holds a small note table, with period, duty and duration per entry. It plays the entries in order by issuing period and duty over the channel's ready/valid input channels, then counts accepted output samples to time each note. It sits between the tile top level and an `apu_pulse` instance, and replaces direct pin-driven configuration with autonomous playback plus optional looping.

## Interface
- `DEPTH`, 8: note table entries; power of two, 2..16.
- `PERIOD_W`, 11: period width; matches `apu_pulse`.
- `DUTY_W`, 2: duty width.
- `DUR_W`, 8: duration width, in output samples.
- `AW`, clog2(DEPTH): table address width (derived).

- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  AW  table write address.
- `wr_data`  in  DUR_W+DUTY_W+PERIOD_W  entry {dur, duty, period}; period in the LSBs.
- `start`  in  1  begin playback at entry 0; honoured only in IDLE.
- `stop`  in  1  abort playback.
- `loop_en`  in  1  at end of sequence, restart at entry 0 instead of halting.
- `busy`  out  1  high in any state other than IDLE.
- `note_idx`  out  AW  index of current entry.
- `done`  out  1  one-cycle pulse when playback ends (end marker without loop, or stop).
- `mute`  out  1  high except in PLAY; top level gates channel output with it.
- `period_s`  out  PERIOD_W  to `apu__period_r`.
- `period_s_vld`  out  1  to `apu__period_r_vld`.
- `period_s_rdy`  in  1  from `apu__period_r_rdy`.
- `duty_s`  out  DUTY_W  to `apu__duty_r`.
- `duty_s_vld`  out  1  to `apu__duty_r_vld`.
- `duty_s_rdy`  in  1  from `apu__duty_r_rdy`.
- `mon_vld`, `mon_rdy`  in  1 each  observed `apu__output_s_vld` / `_rdy`; one sample = both high in a cycle.

## Operation
- Table: DEPTH registers, not reset (contents X after reset). A write with `wr_en` is committed at the clock edge and is allowed in any state.
- FSM states: IDLE, LOAD, SEND, PLAY.
- IDLE: `start` moves to LOAD with idx=0.
- LOAD: latch table[idx] into the cur registers.
  - If cur dur==0, the entry is the end marker:
    - If `loop_en` and idx!=0: idx=0, stay in LOAD.
    - Otherwise: go to IDLE and pulse `done`.
  - If dur!=0: go to SEND with both vld set.
- SEND: `period_s`/`duty_s` are driven from the cur registers.
  - Each vld drops independently in the cycle after its own handshake.
  - When both handshakes are complete (same cycle or different cycles), go to PLAY with cnt=0.
- PLAY: each monitored sample increments cnt.
  - A sample with cnt==dur-1 advances the note.
  - If idx==DEPTH-1, the next state is the end condition: if `loop_en`, idx=0 and go to LOAD; otherwise go to IDLE and pulse `done`.
  - Otherwise idx+1 and go to LOAD.
- Handshake rule: a vld, once asserted, stays high with stable data until its rdy. This rule holds even under `stop`.
- `stop`:
  - In LOAD or PLAY: go to IDLE the next cycle and pulse `done`.
  - In SEND: finish any outstanding handshakes first, then go to IDLE and pulse `done`.
  - `stop` overrides `start` and beats the note-advance logic in the same cycle.
- `start` while busy is ignored.
- cnt width is DUR_W; it never wraps, because it resets on each note advance.

## Timing
- Reset values: state IDLE, idx 0, cnt 0, all vld 0, `period_s`/`duty_s` 0, `busy` 0, `done` 0, `mute` 1.
- All outputs are registered.
- `start` at edge N: LOAD in N+1, `period_s_vld`/`duty_s_vld` high in N+2.
- With rdy held high, both handshakes complete in N+2, PLAY begins in N+3 and `mute` falls in N+3.
- Note advance: the last-sample edge goes to LOAD, then vld rises 2 cycles after that sample. `mute` is high in LOAD and SEND, which gives an inter-note gap of at least 2 cycles.
- A table write in the same cycle LOAD reads the same address: LOAD latches the old data.
- A sample arriving while not in PLAY is ignored.
- `reset` mid-operation: immediate asynchronous return to the reset values. Table contents are retained.

## Test plan
- Reset then idle:
  - Required values: `busy`=0, `mute`=1, all vld 0.
  - `start` with entry0 dur=0: `done` pulses 2 cycles later, no vld is ever raised.
- Two-note play, rdy=1:
  - Table: entry0 {dur 3, duty 2, period 0x1A0}; entry1 {dur 2, duty 1, period 0x7FF}; entry2 dur 0.
  - Feed continuous samples.
  - Required: handshakes carry 0x1A0/2 then 0x7FF/1; PLAY lasts exactly 3 samples, then 2; `done` pulses once; `note_idx` sequence is 0,1,2.
- Skewed ready:
  - Hold `duty_s_rdy` low for 5 cycles with `period_s_rdy`=1.
  - Required: period vld drops after 1 cycle; duty vld and data stay stable for 5 cycles; PLAY entered only after the duty handshake.
- Loop:
  - Same table as the two-note test, with `loop_en`=1.
  - Required: after entry1, idx returns to 0 and period 0x1A0 is re-issued; `done` never pulses.
  - Loop edge case with all DEPTH entries nonzero: wraps from DEPTH-1 to 0.
- Stop and reset:
  - `stop` during PLAY: IDLE next cycle, `done` pulse, `mute`=1.
  - `stop` during SEND with rdy=0: vld held until rdy, then IDLE.
  - Async `reset` mid-PLAY: outputs at reset values before the next clock edge.
- Write collision:
  - Write entry1 in the same cycle LOAD reads entry1.
  - Required: old period issued; the new value is played on the next loop pass.
